// File: rtl/sha256_pkg.sv
// Shared widths and beat-state type for the SHA-256 digest read path.
package sha256_pkg;

    localparam int unsigned DIGEST_W = 256;
    localparam int unsigned WORD_W   = 128;
    localparam int unsigned BEATS    = DIGEST_W / WORD_W;

    typedef enum logic {
        WORD_HI,
        WORD_LO
    } beat_e;

endpackage

// File: rtl/sha256_digest_fifo.sv
// Synchronous DEPTH x DIGEST_W digest FIFO; a push is accepted while full if a pop
// happens in the same cycle.
module sha256_digest_fifo
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DIGEST_W-1:0]       wdata_i,
    output logic [DIGEST_W-1:0]       rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      push_ok_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DIGEST_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                push_ok, pop_ok;

    assign full_o    = (count_q == CntW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign pop_ok    = pop_i && !empty_o;
    // The slot freed by a same-cycle pop makes room for the incoming digest.
    assign push_ok   = push_i && (!full_o || pop_ok);
    assign push_ok_o = push_ok;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sha256_digest_reader.sv
// Buffers 256-bit digests and returns each as two 128-bit words, MSB word first,
// under a read_en pull strobe.
module sha256_digest_reader
    import sha256_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [DIGEST_W-1:0]    digest_in_i,
    input  logic                   digest_valid_i,
    output logic [WORD_W-1:0]      data_out_o,
    output logic                   data_valid_o,
    input  logic                   read_en_i,
    output logic [$clog2(DEPTH):0] digest_pending_o,
    output logic                   overflow_o
);

    beat_e               beat_q, beat_d;
    logic                overflow_q, overflow_d;
    logic [DIGEST_W-1:0] head;
    logic                full, empty, push_ok, pop;

    assign pop = read_en_i && !empty && (beat_q == WORD_LO);

    sha256_digest_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (digest_valid_i),
        .pop_i     (pop),
        .wdata_i   (digest_in_i),
        .rdata_o   (head),
        .full_o    (full),
        .empty_o   (empty),
        .push_ok_o (push_ok),
        .count_o   (digest_pending_o)
    );

    always_comb begin
        beat_d     = beat_q;
        overflow_d = overflow_q || (digest_valid_i && !push_ok);
        if (read_en_i && !empty) begin
            unique case (beat_q)
                WORD_HI: beat_d = WORD_LO;
                WORD_LO: beat_d = WORD_HI;
                default: beat_d = WORD_HI;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            beat_q     <= WORD_HI;
            overflow_q <= 1'b0;
        end else begin
            beat_q     <= beat_d;
            overflow_q <= overflow_d;
        end
    end

    // Output is driven purely from registered storage and state.
    always_comb begin
        data_out_o = '0;
        if (!empty) begin
            data_out_o = (beat_q == WORD_HI) ? head[DIGEST_W-1:WORD_W] : head[WORD_W-1:0];
        end
    end

    assign data_valid_o = !empty;
    assign overflow_o   = overflow_q;

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_sha256_digest_reader.sv
// Directed self-checking bench for sha256_digest_reader with DEPTH=2.
module tb_sha256_digest_reader;

    logic         clk;
    logic         reset;
    logic [255:0] digest_in;
    logic         digest_valid;
    logic [127:0] data_out;
    logic         data_valid;
    logic         read_en;
    logic [1:0]   digest_pending;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] D_PAT =
        256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_NUL =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_X =
        256'h11111111222222223333333344444444555555556666666677777777aaaaaaaa;

    sha256_digest_reader #(
        .DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .digest_in_i      (digest_in),
        .digest_valid_i   (digest_valid),
        .data_out_o       (data_out),
        .data_valid_o     (data_valid),
        .read_en_i        (read_en),
        .digest_pending_o (digest_pending),
        .overflow_o       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        digest_valid = 1'b0;
        read_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [255:0] d);
        digest_in = d;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
    endtask

    // Reads n words back-to-back, comparing each against the expected word list.
    task automatic read_words(input string name, input logic [127:0] exp [4], input int n);
        read_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            total++;
            if (data_valid !== 1'b1 || data_out !== exp[i]) begin
                $display("FAIL %s word %0d: got valid=%b data=%h want valid=1 data=%h",
                         name, i, data_valid, data_out, exp[i]);
                bad++;
            end
            tick();
        end
        read_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (data_valid !== 1'b0) begin
            $display("FAIL reset_valid: got %b want 0", data_valid); bad++;
        end
        total++;
        if (data_out !== 128'h0) begin
            $display("FAIL reset_data: got %h want 0", data_out); bad++;
        end
        total++;
        if (digest_pending !== 2'd0) begin
            $display("FAIL reset_pending: got %0d want 0", digest_pending); bad++;
        end
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL reset_overflow: got %b want 0", overflow); bad++;
        end
    endtask

    task automatic test_single();
        push(D_PAT);
        total++;
        if (data_valid !== 1'b1 || data_out !== D_PAT[255:128] || digest_pending !== 2'd1) begin
            $display("FAIL single_hi: got v=%b d=%h p=%0d want v=1 d=%h p=1",
                     data_valid, data_out, digest_pending, D_PAT[255:128]);
            bad++;
        end
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        total++;
        if (data_valid !== 1'b1 || data_out !== D_PAT[127:0]) begin
            $display("FAIL single_lo: got v=%b d=%h want v=1 d=%h",
                     data_valid, data_out, D_PAT[127:0]);
            bad++;
        end
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        total++;
        if (data_valid !== 1'b0 || data_out !== 128'h0 || digest_pending !== 2'd0) begin
            $display("FAIL single_empty: got v=%b d=%h p=%0d want v=0 d=0 p=0",
                     data_valid, data_out, digest_pending);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp [4];
        exp[0] = 128'hba7816bf8f01cfea414140de5dae2223;
        exp[1] = 128'hb00361a396177a9cb410ff61f20015ad;
        exp[2] = 128'he3b0c44298fc1c149afbf4c8996fb924;
        exp[3] = 128'h27ae41e4649b934ca495991b7852b855;
        push(D_ABC);
        push(D_NUL);
        total++;
        if (digest_pending !== 2'd2) begin
            $display("FAIL b2b_pending: got %0d want 2", digest_pending); bad++;
        end
        read_words("b2b", exp, 4);
        total++;
        if (data_valid !== 1'b0 || digest_pending !== 2'd0) begin
            $display("FAIL b2b_drained: got v=%b p=%0d want v=0 p=0", data_valid, digest_pending);
            bad++;
        end
    endtask

    task automatic test_overflow();
        logic [127:0] exp [4];
        exp[0] = D_ABC[255:128];
        exp[1] = D_ABC[127:0];
        exp[2] = D_NUL[255:128];
        exp[3] = D_NUL[127:0];
        push(D_ABC);
        push(D_NUL);
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_not_yet: got %b want 0", overflow); bad++;
        end
        push(D_X);
        total++;
        if (overflow !== 1'b1 || digest_pending !== 2'd2) begin
            $display("FAIL ovf_set: got ovf=%b p=%0d want ovf=1 p=2", overflow, digest_pending);
            bad++;
        end
        read_words("ovf", exp, 4);
        total++;
        if (data_valid !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL ovf_sticky: got v=%b ovf=%b want v=0 ovf=1", data_valid, overflow);
            bad++;
        end
        do_reset();
        total++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_cleared: got %b want 0", overflow); bad++;
        end
    endtask

    task automatic test_full_push_pop();
        logic [127:0] exp [4];
        exp[0] = D_NUL[255:128];
        exp[1] = D_NUL[127:0];
        exp[2] = D_X[255:128];
        exp[3] = D_X[127:0];
        push(D_ABC);
        push(D_NUL);
        read_en = 1'b1;
        tick();
        total++;
        if (data_out !== D_ABC[127:0]) begin
            $display("FAIL fpp_lo: got %h want %h", data_out, D_ABC[127:0]); bad++;
        end
        digest_in = D_X;
        digest_valid = 1'b1;
        tick();
        digest_valid = 1'b0;
        read_en = 1'b0;
        total++;
        if (overflow !== 1'b0 || digest_pending !== 2'd2) begin
            $display("FAIL fpp_accept: got ovf=%b p=%0d want ovf=0 p=2", overflow, digest_pending);
            bad++;
        end
        read_words("fpp", exp, 4);
        total++;
        if (data_valid !== 1'b0) begin
            $display("FAIL fpp_drained: got %b want 0", data_valid); bad++;
        end
    endtask

    task automatic test_empty_strobe();
        logic [127:0] exp [4];
        exp[0] = D_X[255:128];
        exp[1] = D_X[127:0];
        exp[2] = '0;
        exp[3] = '0;
        read_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        read_en = 1'b0;
        total++;
        if (data_valid !== 1'b0 || digest_pending !== 2'd0) begin
            $display("FAIL strobe_idle: got v=%b p=%0d want v=0 p=0", data_valid, digest_pending);
            bad++;
        end
        push(D_X);
        read_words("strobe", exp, 2);
    endtask

    task automatic test_reset_mid_read();
        logic [127:0] exp [4];
        exp[0] = D_PAT[255:128];
        exp[1] = D_PAT[127:0];
        exp[2] = '0;
        exp[3] = '0;
        push(D_ABC);
        push(D_NUL);
        push(D_X);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (data_valid !== 1'b0 || digest_pending !== 2'd0 || overflow !== 1'b0 ||
            data_out !== 128'h0) begin
            $display("FAIL midreset: got v=%b p=%0d ovf=%b d=%h want v=0 p=0 ovf=0 d=0",
                     data_valid, digest_pending, overflow, data_out);
            bad++;
        end
        push(D_PAT);
        read_words("midreset", exp, 2);
        total++;
        if (data_valid !== 1'b0) begin
            $display("FAIL midreset_drained: got %b want 0", data_valid); bad++;
        end
    endtask

    initial begin
        reset = 1'b1;
        digest_in = '0;
        digest_valid = 1'b0;
        read_en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_empty_strobe();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_digest_reader.md
Name: sha256_digest_reader

Overview:
Output-side companion to the 128-bit SHA-256 write interface. Captures each 256-bit digest pulse from the hash core into a small digest FIFO. Host software reads the FIFO back as 128-bit words using a read_en pull strobe, which mirrors write_en on the input side. Each digest is returned as two beats, most-significant word first, which matches the input side's MSB-first ordering.

Parameters:
DIGEST_W, 256, digest width in bits (fixed for SHA-256)
WORD_W, 128, read word width; DIGEST_W/WORD_W = BEATS = 2
DEPTH, 2, number of buffered digests (power of 2, >= 2)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
digest_in  input  256  digest from hash core
digest_valid  input  1  one-cycle pulse; digest_in is valid in the same cycle
data_out  output  128  current read word; all zeros when empty
data_valid  output  1  a read word is available (FIFO not empty)
read_en  input  1  consume the current word in this cycle
digest_pending  output  clog2(DEPTH)+1  number of digests currently held
overflow  output  1  sticky; a digest was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr, rd_ptr and count go to 0; beat state goes to WORD_HI.
  - overflow goes to 0; data_valid goes to 0; data_out reads 0.
  - Storage contents need not be cleared.
  - Reset asserted mid-read discards all held digests and any partial read.
- Push:
  - On digest_valid with count < DEPTH, write digest_in at wr_ptr.
  - wr_ptr increments and wraps modulo DEPTH.
- Latency: digest_valid sampled at edge N gives data_valid=1 and data_out=digest_in[255:128] after edge N (cycle N+1).
- Beat FSM:
  - WORD_HI: data_out = head[255:128]. read_en with data_valid moves to WORD_LO.
  - WORD_LO: data_out = head[127:0]. read_en with data_valid pops the head, increments rd_ptr (wrapping), and returns to WORD_HI.
- read_en while data_valid=0 is ignored; no state change and no error.
- data_out is a mux of registered storage selected by rd_ptr and the beat state. There is no combinational path from read_en or digest_in to data_out.
- data_valid = (count != 0).
- digest_pending = count.
- Full condition:
  - digest_valid with count == DEPTH and no pop in the same cycle drops the digest and sets overflow=1.
  - overflow holds until reset.
- Simultaneous push and pop (read_en in WORD_LO) in the same cycle:
  - Always accepted, including when the FIFO is full.
  - count is unchanged and both pointers advance.
- Simultaneous push and read_en in WORD_HI:
  - Push proceeds normally.
  - Beat advances to WORD_LO; count increments.
- Empty-to-non-empty: the head word presented is always WORD_HI of the new head.
- count arithmetic uses clog2(DEPTH)+1 bits; it never exceeds DEPTH and never underflows.

Decomposition:
- Shared package sha256_pkg holds:
  - DIGEST_W, WORD_W, BEATS
  - beat state typedef {WORD_HI, WORD_LO}
- Natural sub-module: sha256_digest_fifo, a synchronous DEPTH x DIGEST_W FIFO with push, pop, full, empty and count, plus an allowed-push-when-full-and-popping rule.
- The top level adds the beat FSM, the output mux and the overflow flag.

Test Plan:
- Reset, then digest_valid with digest_in = 0x0123..ef (256-bit, bytes 01..ef repeating) -> next cycle data_valid=1, data_out = upper 128 bits, digest_pending=1. After read_en: lower 128 bits. After a second read_en: data_valid=0, data_out=0, digest_pending=0.
- Push SHA-256("abc") = ba7816bf...f20015ad, then SHA-256("") = e3b0c442...7852b855; read four beats back-to-back -> words in order ba7816bf..., ...f20015ad, e3b0c442..., ...7852b855.
- Push 3 digests with DEPTH=2 and no reads -> third dropped, overflow=1, digest_pending=2. Reading all 4 beats returns only the first two digests; overflow stays 1.
- FIFO full, digest_valid coincident with read_en in WORD_LO -> new digest accepted, overflow stays 0, digest_pending stays 2, and the new digest is read out after the remaining one.
- read_en pulsed while empty for 5 cycles, then one push -> first word returned is the upper half; the earlier strobes have no effect.
- Reset asserted after one beat of a two-digest FIFO has been read -> next cycle data_valid=0, digest_pending=0, overflow=0. A subsequent push reads back starting from the upper half.
